axi_mm_resp: RTL and testbench
==============================

AXI_MM_RESP -- requirements
Module: axi_mm_resp

Interface
REQ-001 SHALL have parameter DEPTH, 256, RAM depth in 128-bit words (power of 2, max 256).
REQ-002 SHALL have parameter BASE, 64'h0, byte base address of the RAM window.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 awaddr  in  64  write burst start byte address.
REQ-006 awid  in  4  write transaction ID.
REQ-007 awlen  in  8  write beats minus 1.
REQ-008 awburst  in  2  burst type; only INCR (2'h1) legal.
REQ-009 awvalid  in  1  write address valid.
REQ-010 awready  out  1  write address ready.
REQ-011 wdata  in  128  write beat data.
REQ-012 wstrb  in  16  byte-lane enables.
REQ-013 wlast  in  1  final write beat.
REQ-014 wvalid  in  1  write data valid.
REQ-015 wready  out  1  write data ready.
REQ-016 bid  out  4  response ID, equals latched awid.
REQ-017 bresp  out  2  write response code.
REQ-018 bvalid  out  1  write response valid.
REQ-019 bready  in  1  write response ready.
REQ-020 araddr  in  64  read burst start byte address.
REQ-021 arid  in  4  read transaction ID.
REQ-022 arlen  in  8  read beats minus 1.
REQ-023 arburst  in  2  burst type; only INCR legal.
REQ-024 arvalid  in  1  read address valid.
REQ-025 arready  out  1  read address ready.
REQ-026 rdata  out  128  read beat data.
REQ-027 rid  out  4  read ID, equals latched arid.
REQ-028 rresp  out  2  read response code.
REQ-029 rlast  out  1  final read beat.
REQ-030 rvalid  out  1  read data valid.
REQ-031 rready  in  1  read data ready.

Function
REQ-032 SHALL treat every beat as 16 bytes; word index = (addr-BASE)>>4, incremented by 1 per beat modulo DEPTH.
REQ-033 SHALL classify a burst as DECERR (2'h3) if start address is outside [BASE, BASE+16*DEPTH); else SLVERR (2'h2) if burst != INCR; else OKAY (2'h0); errored writes SHALL not modify RAM; errored reads SHALL return rdata=0.
REQ-034 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: awready=1 only in W_IDLE, AW handshake latches awaddr/awid/awlen; wready=1 only in W_DATA, each W handshake writes enabled byte lanes same cycle.
REQ-035 W_DATA SHALL exit to W_RESP on the W handshake with wlast=1; a wlast on a beat other than beat awlen, or no wlast on beat awlen, SHALL set bresp=SLVERR (beats past awlen not written, FSM waits for wlast).
REQ-036 W_RESP SHALL hold bvalid=1 with stable bid/bresp until bready; return to W_IDLE the cycle after handshake.
REQ-037 Read FSM R_IDLE->R_FETCH->R_DATA: arready=1 only in R_IDLE; R_FETCH issues RAM read (1-cycle latency); R_DATA drives rvalid=1, holding rdata/rid/rresp/rlast stable until rready.
REQ-038 On R handshake: rlast=1 -> R_IDLE, else -> R_FETCH for next word; throughput one beat per 2 cycles; rlast=1 exactly on beat arlen.
REQ-039 Read and write channels SHALL operate concurrently; a same-cycle RAM read and write to one word SHALL return old data.
REQ-040 awlen=0/arlen=0 SHALL be single-beat bursts; awlen=255 SHALL wrap word index past DEPTH-1 to 0.

Reset
REQ-041 On rst_n low: both FSMs to IDLE; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0; RAM contents not reset; a burst in flight is abandoned, written beats remain.

Structure
REQ-042 Package axi_mm_resp_pkg SHALL hold resp codes (OKAY/SLVERR/DECERR), burst codes, and write/read state enums.
REQ-043 SHALL instantiate one sub-module axi_mm_resp_ram: DEPTH x 128 simple dual-port RAM, 16 byte enables, 1-cycle registered read.

Verification
REQ-044 AW(addr 0x20,id 3,len 0)+W(data A5..,strb FFFF,wlast) -> bvalid, bid=3, bresp=0; AR(0x20,id 5) -> rdata A5.., rid=5, rlast=1, rresp=0.
REQ-045 4-beat INCR write at 0x0 with strb 000F on beat 2, then 4-beat read -> 4 beats, only low 4 bytes of beat 2 updated, rlast on beat 4 only.
REQ-046 AR at BASE+0x1000 (DEPTH=256) len 1 -> 2 beats rresp=3, rdata=0; AW burst=2'h2 -> bresp=2, RAM unchanged.
REQ-047 wlast on beat 1 of len=3 write -> bresp=2, FSM back to W_IDLE after bready.
REQ-048 Hold bready=0 10 cycles, rready=0 10 cycles -> bvalid/rvalid and payloads stable; concurrent read+write complete independently.
REQ-049 Assert rst_n low mid read burst -> rvalid=0 and arready=1 immediately; next AR serviced normally.

Source files
------------

// File: rtl/axi_mm_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_mm_resp_pkg                                                     |
// | Response/burst codes, FSM state encodings and address classifier.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package axi_mm_resp_pkg;

    localparam logic [1:0] c_RESP_OKAY   = 2'h0;
    localparam logic [1:0] c_RESP_SLVERR = 2'h2;
    localparam logic [1:0] c_RESP_DECERR = 2'h3;

    localparam logic [1:0] c_BURST_FIXED = 2'h0;
    localparam logic [1:0] c_BURST_INCR  = 2'h1;
    localparam logic [1:0] c_BURST_WRAP  = 2'h2;

    localparam logic [1:0] c_W_IDLE  = 2'd0;
    localparam logic [1:0] c_W_DATA  = 2'd1;
    localparam logic [1:0] c_W_RESP  = 2'd2;

    localparam logic [1:0] c_R_IDLE  = 2'd0;
    localparam logic [1:0] c_R_FETCH = 2'd1;
    localparam logic [1:0] c_R_DATA  = 2'd2;

    // Decode error outranks an illegal burst type.
    function automatic logic [1:0] classify(input logic [63:0] addr,
                                            input logic [1:0]  burst,
                                            input logic [63:0] base,
                                            input logic [63:0] span);
        if (addr < base || (addr - base) >= span)
            return c_RESP_DECERR;
        if (burst != c_BURST_INCR)
            return c_RESP_SLVERR;
        return c_RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mm_resp_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_mm_resp_ram                                                     |
// | DEPTH x 128 simple dual-port RAM, byte enables, registered read.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module axi_mm_resp_ram #(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [15:0]     wbe,
    input  logic [127:0]    wdata,
    input  logic            re,
    input  logic [IW-1:0]   raddr,
    output logic [127:0]    rdata
);

    logic [127:0] r_mem [DEPTH];
    logic [127:0] r_rdata;

    // Read samples the pre-write contents on a same-word collision.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 16; i++) begin
                if (wbe[i])
                    r_mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re)
            r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axi_mm_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axi_mm_resp                                                         |
// | AXI memory-mapped slave: INCR bursts into a 128-bit wide RAM.       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module axi_mm_resp
    import axi_mm_resp_pkg::*;
#(
    parameter int          DEPTH = 256,
    parameter logic [63:0] BASE  = 64'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [63:0]     awaddr,
    input  logic [3:0]      awid,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [127:0]    wdata,
    input  logic [15:0]     wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [3:0]      bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [63:0]     araddr,
    input  logic [3:0]      arid,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [127:0]    rdata,
    output logic [3:0]      rid,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);

    localparam int          IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] c_SPAN = 64'(DEPTH) << 4;

    // Write channel state
    logic [1:0]     r_w_state;
    logic [3:0]     r_w_id;
    logic [7:0]     r_w_len;
    logic [7:0]     r_w_beat;
    logic [IW-1:0]  r_w_idx;
    logic [1:0]     r_w_code;
    logic           r_w_over;
    logic           r_w_perr;
    logic [1:0]     r_bresp;

    // Read channel state
    logic [1:0]     r_r_state;
    logic [3:0]     r_r_id;
    logic [7:0]     r_r_len;
    logic [7:0]     r_r_beat;
    logic [IW-1:0]  r_r_idx;
    logic [1:0]     r_r_code;

    logic           w_w_at_last;
    logic           w_w_beat_err;
    logic           w_ram_we;
    logic           w_ram_re;
    logic           w_r_last;
    logic [127:0]   w_ram_rdata;

    // A beat is "last" only when it is beat awlen and no overrun happened yet.
    assign w_w_at_last  = (r_w_beat == r_w_len) && !r_w_over;
    assign w_w_beat_err = (wlast != w_w_at_last);
    assign w_ram_we     = (r_w_state == c_W_DATA) && wvalid &&
                          (r_w_code == c_RESP_OKAY) && !r_w_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_state <= c_W_IDLE;
            r_w_id    <= 4'h0;
            r_w_len   <= 8'h0;
            r_w_beat  <= 8'h0;
            r_w_idx   <= '0;
            r_w_code  <= c_RESP_OKAY;
            r_w_over  <= 1'b0;
            r_w_perr  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
        end else begin
            case (r_w_state)
                c_W_IDLE: begin
                    if (awvalid) begin
                        r_w_id    <= awid;
                        r_w_len   <= awlen;
                        r_w_beat  <= 8'h0;
                        r_w_idx   <= IW'((awaddr - BASE) >> 4);
                        r_w_code  <= classify(awaddr, awburst, BASE, c_SPAN);
                        r_w_over  <= 1'b0;
                        r_w_perr  <= 1'b0;
                        r_w_state <= c_W_DATA;
                    end
                end
                c_W_DATA: begin
                    if (wvalid) begin
                        if (!r_w_over) begin
                            r_w_beat <= r_w_beat + 8'd1;
                            r_w_idx  <= r_w_idx + IW'(1);
                        end
                        if (w_w_at_last)
                            r_w_over <= 1'b1;
                        if (wlast) begin
                            r_w_state <= c_W_RESP;
                            if (r_w_code != c_RESP_OKAY)
                                r_bresp <= r_w_code;
                            else if (r_w_perr || w_w_beat_err)
                                r_bresp <= c_RESP_SLVERR;
                            else
                                r_bresp <= c_RESP_OKAY;
                        end else begin
                            r_w_perr <= r_w_perr | w_w_beat_err;
                        end
                    end
                end
                c_W_RESP: begin
                    if (bready)
                        r_w_state <= c_W_IDLE;
                end
                default: r_w_state <= c_W_IDLE;
            endcase
        end
    end

    assign awready = (r_w_state == c_W_IDLE);
    assign wready  = (r_w_state == c_W_DATA);
    assign bvalid  = (r_w_state == c_W_RESP);
    assign bid     = r_w_id;
    assign bresp   = r_bresp;

    assign w_r_last = (r_r_beat == r_r_len);
    assign w_ram_re = (r_r_state == c_R_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r_state <= c_R_IDLE;
            r_r_id    <= 4'h0;
            r_r_len   <= 8'h0;
            r_r_beat  <= 8'h0;
            r_r_idx   <= '0;
            r_r_code  <= c_RESP_OKAY;
        end else begin
            case (r_r_state)
                c_R_IDLE: begin
                    if (arvalid) begin
                        r_r_id    <= arid;
                        r_r_len   <= arlen;
                        r_r_beat  <= 8'h0;
                        r_r_idx   <= IW'((araddr - BASE) >> 4);
                        r_r_code  <= classify(araddr, arburst, BASE, c_SPAN);
                        r_r_state <= c_R_FETCH;
                    end
                end
                c_R_FETCH: r_r_state <= c_R_DATA;
                c_R_DATA: begin
                    if (rready) begin
                        if (w_r_last) begin
                            r_r_state <= c_R_IDLE;
                        end else begin
                            r_r_beat  <= r_r_beat + 8'd1;
                            r_r_idx   <= r_r_idx + IW'(1);
                            r_r_state <= c_R_FETCH;
                        end
                    end
                end
                default: r_r_state <= c_R_IDLE;
            endcase
        end
    end

    // RAM output only changes in R_FETCH, so it is stable through R_DATA.
    assign arready = (r_r_state == c_R_IDLE);
    assign rvalid  = (r_r_state == c_R_DATA);
    assign rlast   = rvalid && w_r_last;
    assign rid     = r_r_id;
    assign rresp   = r_r_code;
    assign rdata   = (rvalid && r_r_code == c_RESP_OKAY) ? w_ram_rdata : 128'h0;

    axi_mm_resp_ram #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (r_w_idx),
        .wbe   (wstrb),
        .wdata (wdata),
        .re    (w_ram_re),
        .raddr (r_r_idx),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_mm_resp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axi_mm_resp                                                      |
// | Randomized bench with a word-array reference model of the RAM.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_axi_mm_resp;

    localparam int          DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h0;

    logic         clk;
    logic         rst_n;
    logic [63:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [63:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [127:0] rdata;
    logic [3:0]   rid;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    axi_mm_resp #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] mdl [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [63:0] addr, input logic [1:0] burst);
        if ((addr - BASE) >= 64'(DEPTH) * 64'd16) return 2'h3;
        if (burst != 2'h1) return 2'h2;
        return 2'h0;
    endfunction

    task automatic axi_write(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input int part_beat,
                             input logic [15:0] part_strb, input bit rnd_strb, input bit fixed_a5,
                             input int bstall);
        logic [1:0] er;
        int idx;
        int t;
        er  = exp_resp(addr, burst);
        idx = (er == 2'h3) ? 0 : int'((addr - BASE) >> 4);
        awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(posedge clk); #1; t++; end
        check("awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            logic [127:0] d;
            logic [15:0]  s;
            d = fixed_a5 ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
            s = (b == part_beat) ? part_strb : (rnd_strb ? 16'($urandom) : 16'hFFFF);
            wdata = d; wstrb = s; wlast = (b == nbeats - 1); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 50) begin @(posedge clk); #1; t++; end
            check("wready", wready, 1);
            @(posedge clk); #1;
            if (er == 2'h0 && b <= int'(len)) begin
                for (int k = 0; k < 16; k++)
                    if (s[k]) mdl[(idx + b) % DEPTH][k*8 +: 8] = d[k*8 +: 8];
            end
            wvalid = 1'b0; wlast = 1'b0;
        end
        if (er == 2'h0 && nbeats != int'(len) + 1) er = 2'h2;
        t = 0;
        while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
        for (int c = 0; c < bstall; c++) begin
            check("bvalid_hold", bvalid, 1);
            check("bid_hold", bid, id);
            check("bresp_hold", bresp, er);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        check("bvalid", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, er);
        @(posedge clk); #1;
        bready = 1'b0;
        check("w_idle_awready", awready, 1);
        check("bvalid_drop", bvalid, 0);
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int rstall);
        logic [1:0] er;
        int idx;
        int t;
        er  = exp_resp(addr, burst);
        idx = (er == 2'h3) ? 0 : int'((addr - BASE) >> 4);
        araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(posedge clk); #1; t++; end
        check("arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            logic [127:0] ed;
            ed = (er == 2'h0) ? mdl[(idx + b) % DEPTH] : 128'h0;
            t = 0;
            while (!rvalid && t < 50) begin @(posedge clk); #1; t++; end
            for (int c = 0; c < rstall; c++) begin
                check("rvalid_hold", rvalid, 1);
                check("rdata_hold", rdata, ed);
                check("rid_hold", rid, id);
                check("rlast_hold", rlast, (b == int'(len)));
                @(posedge clk); #1;
            end
            rready = 1'b1;
            check("rvalid", rvalid, 1);
            check("rdata", rdata, ed);
            check("rid", rid, id);
            check("rresp", rresp, er);
            check("rlast", rlast, (b == int'(len)));
            @(posedge clk); #1;
            rready = 1'b0;
        end
        check("r_idle_arready", arready, 1);
        check("rvalid_drop", rvalid, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_bid", bid, 0);
        check("rst_rid", rid, 0);
        check("rst_rdata", rdata, 0);
    endtask

    function automatic logic [63:0] rnd_addr();
        if ($urandom_range(0, 7) == 0)
            return BASE + 64'(DEPTH) * 64'd16 + 64'($urandom_range(0, 65535));
        return BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd16 + 64'($urandom_range(0, 15));
    endfunction

    function automatic logic [1:0] rnd_burst();
        case ($urandom_range(0, 9))
            0:       return 2'h0;
            1:       return 2'h2;
            2:       return 2'h3;
            default: return 2'h1;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awburst = 2'h1; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arburst = 2'h1; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill the whole RAM with a wrapping 256-beat burst, then read it back.
        axi_write(64'd250 * 16, 4'd1, 8'd255, 2'h1, 256, -1, 16'h0, 1'b0, 1'b0, 0);
        axi_read(64'd250 * 16, 4'd2, 8'd255, 2'h1, 0);

        axi_write(64'h20, 4'd3, 8'd0, 2'h1, 1, -1, 16'h0, 1'b0, 1'b1, 0);
        axi_read(64'h20, 4'd5, 8'd0, 2'h1, 0);

        axi_write(64'h0, 4'd4, 8'd3, 2'h1, 4, 2, 16'h000F, 1'b0, 1'b0, 0);
        axi_read(64'h0, 4'd6, 8'd3, 2'h1, 0);

        axi_read(BASE + 64'h1000, 4'd7, 8'd1, 2'h1, 0);
        axi_write(64'h100, 4'd8, 8'd0, 2'h2, 1, -1, 16'h0, 1'b0, 1'b0, 0);
        axi_read(64'h100, 4'd8, 8'd0, 2'h1, 0);

        axi_write(64'h200, 4'd9, 8'd3, 2'h1, 2, -1, 16'h0, 1'b0, 1'b0, 0);
        axi_write(64'h240, 4'd10, 8'd1, 2'h1, 4, -1, 16'h0, 1'b0, 1'b0, 0);
        axi_read(64'h200, 4'd11, 8'd7, 2'h1, 0);

        fork
            axi_write(64'h300, 4'd12, 8'd3, 2'h1, 4, -1, 16'h0, 1'b1, 1'b0, 10);
            axi_read(64'h800, 4'd13, 8'd3, 2'h1, 10);
        join
        axi_read(64'h300, 4'd14, 8'd3, 2'h1, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] len;
            int nb;
            len = 8'($urandom_range(0, 7));
            nb  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : int'(len) + 1;
            if ($urandom_range(0, 1) == 0)
                axi_write(rnd_addr(), 4'($urandom), len, rnd_burst(), nb, -1, 16'h0, 1'b1, 1'b0,
                          $urandom_range(0, 2));
            else
                axi_read(rnd_addr(), 4'($urandom), len, rnd_burst(), $urandom_range(0, 2));
        end

        // Reset in the middle of a read burst.
        araddr = 64'h0; arid = 4'd9; arlen = 8'd7; arburst = 2'h1; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(64'h0, 4'd15, 8'd3, 2'h1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
